// File: rtl/bicubic_weight_gen.sv
// Bicubic scaler weight generator: walks the destination raster, accumulates source
// positions and produces Keys (a = -0.5) tap weight magnitudes for x and y.
module bicubic_weight_gen #(
    parameter int FRACTION_BITS = 8,
    parameter int COEFF_WIDTH   = 9,
    parameter int POS_WIDTH     = 20,
    parameter int DIM_WIDTH     = 12
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [DIM_WIDTH-1:0]           dst_w,
    input  logic [DIM_WIDTH-1:0]           dst_h,
    input  logic [POS_WIDTH-1:0]           step_x,
    input  logic [POS_WIDTH-1:0]           step_y,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [POS_WIDTH-FRACTION_BITS-1:0] src_x,
    output logic [POS_WIDTH-FRACTION_BITS-1:0] src_y,
    output logic                           line_last,
    output logic                           frame_last,
    output logic [COEFF_WIDTH-1:0]         bi_x0,
    output logic [COEFF_WIDTH-1:0]         bi_x1,
    output logic [COEFF_WIDTH-1:0]         bi_x2,
    output logic [COEFF_WIDTH-1:0]         bi_x3,
    output logic [COEFF_WIDTH-1:0]         bi_y0,
    output logic [COEFF_WIDTH-1:0]         bi_y1,
    output logic [COEFF_WIDTH-1:0]         bi_y2,
    output logic [COEFF_WIDTH-1:0]         bi_y3
);
    localparam int IW = POS_WIDTH - FRACTION_BITS;
    localparam int FB = FRACTION_BITS;
    localparam int MW = FRACTION_BITS + 5;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state_reg;
    logic [DIM_WIDTH-1:0] dim_w_reg, dim_h_reg, out_x_reg, out_y_reg;
    logic [POS_WIDTH-1:0] step_x_reg, step_y_reg, pos_x_reg, pos_y_reg;
    logic                 busy_reg, frame_done_reg;
    logic                 s0_valid_reg, s0_ll_reg, s0_fl_reg;
    logic                 s1_valid_reg, s1_ll_reg, s1_fl_reg;
    logic                 s2_valid_reg, s2_ll_reg, s2_fl_reg;
    logic                 out_valid_reg, line_last_reg, frame_last_reg;

    logic adv, issue, x_last, y_last;

    assign adv    = !out_valid_reg || out_ready;
    assign issue  = adv && (state_reg == RUN);
    assign x_last = (out_x_reg == dim_w_reg - DIM_WIDTH'(1));
    assign y_last = (out_y_reg == dim_h_reg - DIM_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            dim_w_reg      <= '0;
            dim_h_reg      <= '0;
            out_x_reg      <= '0;
            out_y_reg      <= '0;
            step_x_reg     <= '0;
            step_y_reg     <= '0;
            pos_x_reg      <= '0;
            pos_y_reg      <= '0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            s0_valid_reg   <= 1'b0;
            s0_ll_reg      <= 1'b0;
            s0_fl_reg      <= 1'b0;
            s1_valid_reg   <= 1'b0;
            s1_ll_reg      <= 1'b0;
            s1_fl_reg      <= 1'b0;
            s2_valid_reg   <= 1'b0;
            s2_ll_reg      <= 1'b0;
            s2_fl_reg      <= 1'b0;
            out_valid_reg  <= 1'b0;
            line_last_reg  <= 1'b0;
            frame_last_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            if (adv) begin
                s0_valid_reg  <= issue;
                s1_valid_reg  <= s0_valid_reg;
                s1_ll_reg     <= s0_ll_reg;
                s1_fl_reg     <= s0_fl_reg;
                s2_valid_reg  <= s1_valid_reg;
                s2_ll_reg     <= s1_ll_reg;
                s2_fl_reg     <= s1_fl_reg;
                out_valid_reg <= s2_valid_reg;
                if (s2_valid_reg) begin
                    line_last_reg  <= s2_ll_reg;
                    frame_last_reg <= s2_fl_reg;
                end
            end
            if (issue) begin
                s0_ll_reg <= x_last;
                s0_fl_reg <= x_last && y_last;
            end
            case (state_reg)
                IDLE: begin
                    if (start && (dst_w != '0) && (dst_h != '0)) begin
                        dim_w_reg  <= dst_w;
                        dim_h_reg  <= dst_h;
                        step_x_reg <= step_x;
                        step_y_reg <= step_y;
                        out_x_reg  <= '0;
                        out_y_reg  <= '0;
                        pos_x_reg  <= '0;
                        pos_y_reg  <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    if (adv) begin
                        if (x_last) begin
                            out_x_reg <= '0;
                            pos_x_reg <= '0;
                            out_y_reg <= out_y_reg + DIM_WIDTH'(1);
                            pos_y_reg <= pos_y_reg + step_y_reg;
                            if (y_last) state_reg <= DRAIN;
                        end else begin
                            out_x_reg <= out_x_reg + DIM_WIDTH'(1);
                            pos_x_reg <= pos_x_reg + step_x_reg;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid_reg && out_ready && frame_last_reg) begin
                        frame_done_reg <= 1'b1;
                        busy_reg       <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Identical datapath per axis: gi = 0 is x, gi = 1 is y.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_axis
            logic [POS_WIDTH-1:0]   pos;
            logic [IW-1:0]          s0_int_reg, s1_int_reg, s2_int_reg, src_reg;
            logic [FB-1:0]          s0_t_reg, s1_t_reg, s2_t_reg;
            logic [FB-1:0]          s1_t2_reg, s2_t2_reg, s2_t3_reg;
            logic [2*FB-1:0]        t_ext, t2_ext, t1_ext, sq, cube;
            logic [COEFF_WIDTH-1:0] w0_reg, w1_reg, w2_reg, w3_reg;
            logic [COEFF_WIDTH-1:0] w0, w1, w2, w3;
            logic signed [MW-1:0]   a_t, a_t2, a_t3, w0_s, w1_s, w2_s, w3_s;

            localparam logic signed [MW-1:0] K3  = MW'(3);
            localparam logic signed [MW-1:0] K5  = MW'(5);
            localparam logic signed [MW-1:0] ONE = MW'(1 << FRACTION_BITS);

            assign pos    = (gi == 0) ? pos_x_reg : pos_y_reg;
            assign t_ext  = {{FB{1'b0}}, s0_t_reg};
            assign sq     = t_ext * t_ext;
            assign t2_ext = {{FB{1'b0}}, s1_t2_reg};
            assign t1_ext = {{FB{1'b0}}, s1_t_reg};
            assign cube   = t2_ext * t1_ext;

            assign a_t  = $signed({5'b0, s2_t_reg});
            assign a_t2 = $signed({5'b0, s2_t2_reg});
            assign a_t3 = $signed({5'b0, s2_t3_reg});
            assign w0_s = ((a_t + a_t3) >>> 1) - a_t2;
            assign w1_s = ONE - ((K5 * a_t2 - K3 * a_t3) >>> 1);
            assign w2_s = ((a_t2 <<< 2) + a_t - K3 * a_t3) >>> 1;
            assign w3_s = (a_t2 - a_t3) >>> 1;
            // Truncation can push the tap-0 expression slightly negative; clamp to zero.
            assign w0 = w0_s[MW-1] ? '0 : w0_s[COEFF_WIDTH-1:0];
            assign w1 = w1_s[COEFF_WIDTH-1:0];
            assign w2 = w2_s[COEFF_WIDTH-1:0];
            assign w3 = w3_s[COEFF_WIDTH-1:0];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s0_int_reg <= '0;
                    s0_t_reg   <= '0;
                    s1_int_reg <= '0;
                    s1_t_reg   <= '0;
                    s1_t2_reg  <= '0;
                    s2_int_reg <= '0;
                    s2_t_reg   <= '0;
                    s2_t2_reg  <= '0;
                    s2_t3_reg  <= '0;
                    src_reg    <= '0;
                    w0_reg     <= '0;
                    w1_reg     <= '0;
                    w2_reg     <= '0;
                    w3_reg     <= '0;
                end else if (adv) begin
                    if (issue) begin
                        s0_int_reg <= pos[POS_WIDTH-1:FB];
                        s0_t_reg   <= pos[FB-1:0];
                    end
                    s1_int_reg <= s0_int_reg;
                    s1_t_reg   <= s0_t_reg;
                    s1_t2_reg  <= sq[2*FB-1:FB];
                    s2_int_reg <= s1_int_reg;
                    s2_t_reg   <= s1_t_reg;
                    s2_t2_reg  <= s1_t2_reg;
                    s2_t3_reg  <= cube[2*FB-1:FB];
                    if (s2_valid_reg) begin
                        src_reg <= s2_int_reg;
                        w0_reg  <= w0;
                        w1_reg  <= w1;
                        w2_reg  <= w2;
                        w3_reg  <= w3;
                    end
                end
            end
        end
    endgenerate

    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign out_valid  = out_valid_reg;
    assign line_last  = line_last_reg;
    assign frame_last = frame_last_reg;
    assign src_x      = gen_axis[0].src_reg;
    assign src_y      = gen_axis[1].src_reg;
    assign bi_x0      = gen_axis[0].w0_reg;
    assign bi_x1      = gen_axis[0].w1_reg;
    assign bi_x2      = gen_axis[0].w2_reg;
    assign bi_x3      = gen_axis[0].w3_reg;
    assign bi_y0      = gen_axis[1].w0_reg;
    assign bi_y1      = gen_axis[1].w1_reg;
    assign bi_y2      = gen_axis[1].w2_reg;
    assign bi_y3      = gen_axis[1].w3_reg;
endmodule

// File: tb/tb_bicubic_weight_gen.sv
// Directed bench for bicubic_weight_gen: hand-computed raster, weight, stall,
// reset, ignored-start and wrap vectors checked with immediate assertions.
module tb_bicubic_weight_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] dst_w = '0, dst_h = '0;
    logic [19:0] step_x = '0, step_y = '0;
    logic        busy, frame_done, out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] src_x, src_y;
    logic        line_last, frame_last;
    logic [8:0]  bi_x0, bi_x1, bi_x2, bi_x3, bi_y0, bi_y1, bi_y2, bi_y3;

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] e_sx [16];
    logic [11:0] e_sy [16];
    logic [35:0] e_bx [16];
    logic [35:0] e_by [16];
    logic        e_ll [16];
    logic        e_fl [16];

    bicubic_weight_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dst_w(dst_w), .dst_h(dst_h), .step_x(step_x), .step_y(step_y),
        .busy(busy), .frame_done(frame_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .src_x(src_x), .src_y(src_y),
        .line_last(line_last), .frame_last(frame_last),
        .bi_x0(bi_x0), .bi_x1(bi_x1), .bi_x2(bi_x2), .bi_x3(bi_x3),
        .bi_y0(bi_y0), .bi_y1(bi_y1), .bi_y2(bi_y2), .bi_y3(bi_y3)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-computed Keys weights (w0,w1,w2,w3) for the fractions exercised here.
    function automatic logic [35:0] wt(input int t);
        case (t)
            0:       wt = {9'd0,  9'd256, 9'd0,   9'd0};
            64:      wt = {9'd18, 9'd222, 9'd58,  9'd6};
            128:     wt = {9'd16, 9'd144, 9'd144, 9'd16};
            192:     wt = {9'd6,  9'd58,  9'd222, 9'd18};
            default: wt = 'x;
        endcase
    endfunction

    task automatic set_exp(input int i, input int sx, input int sy, input int tx,
                           input int ty, input bit ll, input bit fl);
        e_sx[i] = 12'(sx);
        e_sy[i] = 12'(sy);
        e_bx[i] = wt(tx);
        e_by[i] = wt(ty);
        e_ll[i] = ll;
        e_fl[i] = fl;
    endtask

    task automatic start_frame(input int w, input int h, input int sx, input int sy);
        @(posedge clk); #1;
        start = 1'b1; dst_w = 12'(w); dst_h = 12'(h);
        step_x = 20'(sx); step_y = 20'(sy);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic collect(input string name, input int n, input int stall_at,
                           input int stall_len, input bit exp_done, input int exp_cyc);
        int idx = 0;
        int cyc = 0;
        int last_cyc = 0;
        int stall_left = stall_len;
        while (idx < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                chk($sformatf("%s[%0d] src_x", name, idx), 64'(src_x), 64'(e_sx[idx]));
                chk($sformatf("%s[%0d] src_y", name, idx), 64'(src_y), 64'(e_sy[idx]));
                chk($sformatf("%s[%0d] bi_x", name, idx),
                    64'({bi_x0, bi_x1, bi_x2, bi_x3}), 64'(e_bx[idx]));
                chk($sformatf("%s[%0d] bi_y", name, idx),
                    64'({bi_y0, bi_y1, bi_y2, bi_y3}), 64'(e_by[idx]));
                chk($sformatf("%s[%0d] tags", name, idx),
                    64'({line_last, frame_last}), 64'({e_ll[idx], e_fl[idx]}));
                $display("%s out %0d: src=(%0h,%0h) bx=%0d,%0d,%0d,%0d ll=%0b fl=%0b ready=%0b",
                         name, idx, src_x, src_y, bi_x0, bi_x1, bi_x2, bi_x3,
                         line_last, frame_last, !(idx == stall_at && stall_left > 0));
                if (idx == stall_at && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                    last_cyc = cyc;
                    idx++;
                end
            end
        end
        chk({name, " count"}, 64'(idx), 64'(n));
        if (exp_cyc > 0) chk({name, " cycles"}, 64'(last_cyc), 64'(exp_cyc));
        if (exp_done) begin
            @(negedge clk);
            chk({name, " frame_done"}, 64'({frame_done, busy}), 64'(2'b10));
            @(negedge clk);
            chk({name, " frame_done end"}, 64'(frame_done), 64'(0));
        end
    endtask

    initial begin
        int extra;
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset ctl", 64'({out_valid, busy, frame_done, line_last, frame_last}), 64'(0));
        chk("reset src", 64'({src_x, src_y}), 64'(0));
        chk("reset bi", 64'({bi_x0, bi_x1, bi_x2, bi_x3, bi_y0, bi_y1, bi_y2, bi_y3}), 64'(0));
        rst_n = 1'b1;

        // 4x2 unit step: integer positions, identity weights
        for (int i = 0; i < 8; i++)
            set_exp(i, i % 4, i / 4, 0, 0, (i % 4) == 3, i == 7);
        start_frame(4, 2, 'h100, 'h100);
        collect("unit", 8, -1, 0, 1'b1, 12);

        // 4x1 quarter step with a start pulse while busy (must be ignored)
        set_exp(0, 0, 0, 0,   0, 0, 0);
        set_exp(1, 0, 0, 64,  0, 0, 0);
        set_exp(2, 0, 0, 128, 0, 0, 0);
        set_exp(3, 0, 0, 192, 0, 1, 1);
        start_frame(4, 1, 'h40, 'h100);
        start = 1'b1; dst_w = 12'd2; dst_h = 12'd1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy held", 64'(busy), 64'(1));
        collect("quarter", 4, -1, 0, 1'b1, 0);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid || busy || frame_done) extra++;
        end
        chk("start while busy ignored", 64'(extra), 64'(0));

        // Zero-width start is ignored
        @(posedge clk); #1;
        start = 1'b1; dst_w = 12'd0; dst_h = 12'd3;
        @(posedge clk); #1;
        start = 1'b0;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid || busy || frame_done) extra++;
        end
        chk("zero dim ignored", 64'(extra), 64'(0));

        // 8x1 half step, 3-cycle stall on the 2nd output
        for (int i = 0; i < 8; i++)
            set_exp(i, i / 2, 0, (i % 2) * 128, 0, i == 7, i == 7);
        start_frame(8, 1, 'h80, 'h80);
        collect("stall", 8, 1, 3, 1'b1, 15);

        // Wrap of the x accumulator
        set_exp(0, 'h000, 0, 0, 0, 0, 0);
        set_exp(1, 'hFFF, 0, 0, 0, 0, 0);
        set_exp(2, 'hFFE, 0, 0, 0, 1, 1);
        start_frame(3, 1, 'hFFF00, 'h100);
        collect("wrap", 3, -1, 0, 1'b1, 7);

        // Reset during output 5 of a 4x4 frame
        for (int i = 0; i < 16; i++)
            set_exp(i, i % 4, i / 4, 0, 0, (i % 4) == 3, i == 15);
        start_frame(4, 4, 'h100, 'h100);
        collect("prereset", 4, -1, 0, 1'b0, 0);
        @(negedge clk);
        chk("output 5 valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("midreset ctl", 64'({out_valid, busy, frame_done, line_last, frame_last}), 64'(0));
        chk("midreset data", 64'({src_x, src_y, bi_x1, bi_y1}), 64'(0));
        $display("mid-frame reset applied");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid || busy || frame_done) extra++;
        end
        chk("no partial frame", 64'(extra), 64'(0));
        set_exp(0, 0, 0, 0, 0, 0, 0);
        set_exp(1, 1, 0, 0, 0, 1, 1);
        start_frame(2, 1, 'h100, 'h100);
        collect("postreset", 2, -1, 0, 1'b1, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
